// File: rtl/slib_uart_tx_serializer.sv
// rtl/slib_uart_tx_serializer.sv - async UART frame serializer for the TX path
//
// Purpose:
//   Serialises one parallel character into an asynchronous UART frame.
//   The frame is a start bit, 5-8 data bits sent LSB first, an optional parity
//   bit, and then 1, 1.5 or 2 stop bits. SOUT is paced by an oversampled baud
//   enable. The block sits between the TX holding register/FIFO and the SOUT pad.
//
// Ports:
//   CLK        system clock, all logic on posedge
//   RST_N      asynchronous active-low reset
//   TXCLK      baud x OVERSAMPLE enable, one CLK pulse per tick
//   CLEAR      synchronous abort: drop the frame and return to idle
//   TXSTART    start request, honoured only while idle
//   DIN        character, latched on an accepted TXSTART
//   WLS        word length 00=5 .. 11=8, latched with DIN
//   STB        stop bits: 0=1 stop, 1=2 stop (1.5 when WLS=00), latched
//   PEN        parity enable, latched
//   EPS        even parity select, latched
//   SP         stick parity, latched
//   BC         break control, live: forces SOUT low
//   SOUT       registered serial output, idle high
//   TXFINISHED one CLK pulse when a frame completes normally

module slib_uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TXCLK,
  input  logic       CLEAR,
  input  logic       TXSTART,
  input  logic [7:0] DIN,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  output logic       SOUT,
  output logic       TXFINISHED
);

  localparam int CW = $clog2(2 * OVERSAMPLE);
  localparam logic [CW-1:0] OS_M1   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS15_M1 = CW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [CW-1:0] OS2_M1  = CW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    din_q;
  logic [1:0]    wls_q;
  logic          stb_q;
  logic          pen_q;
  logic          eps_q;
  logic          sp_q;

  logic [7:0]    data_mask;
  logic          par_bit;
  logic          data_last;
  logic [CW-1:0] len_m1;
  logic          last_tick;
  logic          line_lvl;

  // Bits above the word length must not disturb the parity.
  assign data_mask = 8'hFF >> (2'd3 - wls_q);

  // Stick parity sends the constant ~EPS; otherwise EPS=1 sends the plain XOR.
  assign par_bit = sp_q ? ~eps_q : (^(din_q & data_mask)) ^ ~eps_q;

  // The last data index is N-1 = 4 + WLS, which is just {1, WLS}.
  assign data_last = (bit_idx == {1'b1, wls_q});

  always_comb begin
    len_m1 = OS_M1;
    if (state == S_STOP) begin
      if (!stb_q) begin
        len_m1 = OS_M1;
      end else if (wls_q == 2'b00) begin
        len_m1 = OS15_M1;
      end else begin
        len_m1 = OS2_M1;
      end
    end
  end

  assign last_tick = (tick_cnt == len_m1);

  // Line level that the current state presents. SOUT registers it one CLK later.
  always_comb begin
    line_lvl = 1'b1;
    case (state)
      S_START: line_lvl = 1'b0;
      S_DATA:  line_lvl = din_q[bit_idx];
      S_PAR:   line_lvl = par_bit;
      default: line_lvl = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      din_q      <= '0;
      wls_q      <= '0;
      stb_q      <= 1'b0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      SOUT       <= 1'b1;
      TXFINISHED <= 1'b0;
    end else begin
      TXFINISHED <= 1'b0;
      if (CLEAR) begin
        state    <= S_IDLE;
        tick_cnt <= '0;
        bit_idx  <= '0;
        SOUT     <= ~BC;
      end else begin
        SOUT <= BC ? 1'b0 : line_lvl;
        if (state == S_IDLE) begin
          // A tick arriving together with the request is not counted.
          if (TXSTART) begin
            din_q    <= DIN;
            wls_q    <= WLS;
            stb_q    <= STB;
            pen_q    <= PEN;
            eps_q    <= EPS;
            sp_q     <= SP;
            tick_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_START;
          end
        end else if (TXCLK) begin
          if (last_tick) begin
            tick_cnt <= '0;
            case (state)
              S_START: state <= S_DATA;
              S_DATA: begin
                if (data_last) begin
                  state <= pen_q ? S_PAR : S_STOP;
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                end
              end
              S_PAR: state <= S_STOP;
              S_STOP: begin
                state      <= S_IDLE;
                TXFINISHED <= 1'b1;
              end
              default: state <= S_IDLE;
            endcase
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_slib_uart_tx_serializer.sv
// tb/tb_slib_uart_tx_serializer.sv - self-checking bench for slib_uart_tx_serializer

module tb_slib_uart_tx_serializer;

  localparam int OS = 16;

  logic       CLK     = 1'b0;
  logic       RST_N   = 1'b0;
  logic       TXCLK   = 1'b0;
  logic       CLEAR   = 1'b0;
  logic       TXSTART = 1'b0;
  logic [7:0] DIN     = 8'h00;
  logic [1:0] WLS     = 2'b00;
  logic       STB     = 1'b0;
  logic       PEN     = 1'b0;
  logic       EPS     = 1'b0;
  logic       SP      = 1'b0;
  logic       BC      = 1'b0;
  logic       SOUT;
  logic       TXFINISHED;

  slib_uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST_N(RST_N), .TXCLK(TXCLK), .CLEAR(CLEAR), .TXSTART(TXSTART),
    .DIN(DIN), .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
    .SOUT(SOUT), .TXFINISHED(TXFINISHED)
  );

  always #5 CLK = ~CLK;

  int checks    = 0;
  int failures  = 0;
  bit chk_en    = 1'b0;
  bit rand_mode = 1'b0;
  int cyc       = 0;

  // Reference model: a frame is a list of (line level, length in ticks) segments.
  bit   m_busy = 1'b0;
  int   m_nseg = 0;
  int   m_seg  = 0;
  int   m_tcnt = 0;
  bit   m_lvl [0:11];
  int   m_len [0:11];
  bit   m_now;
  logic exp_sout = 1'b1;
  logic exp_fin  = 1'b0;

  task automatic add_seg(input bit l, input int len);
    m_lvl[m_nseg] = l;
    m_len[m_nseg] = len;
    m_nseg++;
  endtask

  task automatic build_frame();
    int n;
    bit p;
    n = 5 + int'(WLS);
    p = 1'b0;
    m_nseg = 0;
    add_seg(1'b0, OS);
    for (int i = 0; i < n; i++) begin
      add_seg(DIN[i], OS);
      p = p ^ DIN[i];
    end
    if (PEN) add_seg(SP ? ~EPS : (EPS ? p : ~p), OS);
    add_seg(1'b1, !STB ? OS : ((WLS == 2'b00) ? (OS * 3) / 2 : 2 * OS));
    m_busy = 1'b1;
    m_seg  = 0;
    m_tcnt = 0;
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_busy   = 1'b0;
      m_seg    = 0;
      m_tcnt   = 0;
      exp_sout = 1'b1;
      exp_fin  = 1'b0;
    end else begin
      m_now   = m_busy ? m_lvl[m_seg] : 1'b1;
      exp_fin = 1'b0;
      if (CLEAR) begin
        m_busy   = 1'b0;
        exp_sout = ~BC;
      end else begin
        exp_sout = BC ? 1'b0 : m_now;
        if (!m_busy) begin
          if (TXSTART) build_frame();
        end else if (TXCLK) begin
          m_tcnt++;
          if (m_tcnt == m_len[m_seg]) begin
            m_tcnt = 0;
            m_seg++;
            if (m_seg == m_nseg) begin
              m_busy  = 1'b0;
              exp_fin = 1'b1;
            end
          end
        end
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      checks++;
      if (SOUT !== exp_sout) begin
        failures++;
        $display("FAIL sout cyc=%0d got=%b exp=%b", cyc, SOUT, exp_sout);
      end
      checks++;
      if (TXFINISHED !== exp_fin) begin
        failures++;
        $display("FAIL txfinished cyc=%0d got=%b exp=%b", cyc, TXFINISHED, exp_fin);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (rand_mode) TXCLK = ($urandom_range(0, 2) == 0);
    else           TXCLK = ((cyc % 4) == 0);
  endtask

  // Starts a frame and follows it to TXFINISHED, recording the tick count and
  // the line level sampled in the middle of every bit.
  task automatic send(input logic [7:0] d, input logic [1:0] w, input logic stb,
                      input logic pen, input logic eps, input logic sp,
                      input bit poke, input bit bcp,
                      output int ticks, output logic [11:0] cap);
    int k;
    int n;
    bit tk;
    DIN = d; WLS = w; STB = stb; PEN = pen; EPS = eps; SP = sp;
    TXSTART = 1'b1;
    step();
    TXSTART = 1'b0;
    k = 0;
    n = 0;
    cap = '0;
    while (n < 5000) begin
      tk = TXCLK;
      step();
      n++;
      if (tk) begin
        k++;
        if ((k % 16) == 8 && (k / 16) < 12) cap[k / 16] = SOUT;
      end
      TXSTART = poke && tk && (k == 40);
      if (poke && tk && k == 40) DIN = ~d;
      BC = bcp && (k >= 50) && (k < 52);
      if (bcp && tk && k == 51) chk("bc_forces_low", {31'd0, SOUT}, 32'd0);
      if (TXFINISHED) break;
    end
    if (n >= 5000) begin
      failures++;
      $display("FAIL send_timeout got=no_txfinished exp=txfinished");
    end
    TXSTART = 1'b0;
    BC = 1'b0;
    ticks = k;
  endtask

  task automatic run_ticks(input int nt, output int nfin);
    int k;
    int n;
    k = 0;
    n = 0;
    nfin = 0;
    while (k < nt && n < nt * 10 + 100) begin
      if (TXCLK) k++;
      step();
      n++;
      if (TXFINISHED) nfin++;
    end
  endtask

  initial begin
    int          ticks;
    int          nfin;
    logic [11:0] cap;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_sout", {31'd0, SOUT}, 32'd1);
    chk("reset_fin", {31'd0, TXFINISHED}, 32'd0);
    RST_N  = 1'b1;
    chk_en = 1'b1;
    repeat (5) step();

    // 8N1 0x55, with a mid-frame TXSTART and DIN change that must be ignored.
    send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ticks, cap);
    chk("8n1_ticks", ticks, 160);
    chk("8n1_bits", {20'd0, cap & 12'h3FF}, 32'h2AA);

    // 7E1 0xB5: bit 7 never sent, parity 0; odd parity gives 1.
    send(8'hB5, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ticks, cap);
    chk("7e1_ticks", ticks, 160);
    chk("7e1_bits", {20'd0, cap & 12'h3FF}, 32'h26A);
    send(8'hB5, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ticks, cap);
    chk("7o1_bits", {20'd0, cap & 12'h3FF}, 32'h36A);

    // Stop length: 1.5 bits for 5-bit words, 2 bits otherwise.
    send(8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ticks, cap);
    chk("5n15_ticks", ticks, 120);
    chk("5n15_bits", {25'd0, cap[6:0]}, 32'h7E);
    send(8'h1F, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ticks, cap);
    chk("8n2_ticks", ticks, 176);

    // Stick parity is constant ~EPS regardless of data.
    send(8'($urandom), 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ticks, cap);
    chk("stick1_par", {31'd0, cap[9]}, 32'd0);
    chk("stick1_ticks", ticks, 176);
    send(8'($urandom), 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ticks, cap);
    chk("stick0_par", {31'd0, cap[9]}, 32'd1);

    // Back-to-back: request in the TXFINISHED cycle, start bit with no gap.
    send(8'hA3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ticks, cap);
    DIN = 8'h00;
    TXSTART = 1'b1;
    step();
    TXSTART = 1'b0;
    step();
    chk("b2b_start_low", {31'd0, SOUT}, 32'd0);
    run_ticks(170, nfin);
    chk("b2b_fin_count", nfin, 1);

    // BC pulse mid-frame: SOUT forced low, frame timing unchanged.
    send(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ticks, cap);
    chk("bc_ticks", ticks, 160);

    // CLEAR during data bit 3.
    DIN = 8'h00; WLS = 2'b11; STB = 1'b0; PEN = 1'b0;
    TXSTART = 1'b1;
    step();
    TXSTART = 1'b0;
    run_ticks(66, nfin);
    chk("pre_clear_low", {31'd0, SOUT}, 32'd0);
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    chk("clear_sout", {31'd0, SOUT}, 32'd1);
    run_ticks(200, nfin);
    chk("clear_no_fin", nfin, 0);

    // Asynchronous reset mid-frame.
    TXSTART = 1'b1;
    step();
    TXSTART = 1'b0;
    run_ticks(30, nfin);
    chk("pre_reset_low", {31'd0, SOUT}, 32'd0);
    RST_N = 1'b0;
    #1;
    chk("reset_mid_sout", {31'd0, SOUT}, 32'd1);
    chk("reset_mid_fin", {31'd0, TXFINISHED}, 32'd0);
    step();
    RST_N = 1'b1;
    run_ticks(200, nfin);
    chk("reset_no_fin", nfin, 0);

    // Randomised traffic against the model.
    rand_mode = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      TXSTART = ($urandom_range(0, 29) == 0);
      DIN     = 8'($urandom);
      WLS     = 2'($urandom_range(0, 3));
      STB     = 1'($urandom_range(0, 1));
      PEN     = 1'($urandom_range(0, 1));
      EPS     = 1'($urandom_range(0, 1));
      SP      = 1'($urandom_range(0, 1));
      BC      = ($urandom_range(0, 99) < 2);
      CLEAR   = ($urandom_range(0, 1499) == 0);
      step();
    end
    TXSTART = 1'b0;
    BC      = 1'b0;
    CLEAR   = 1'b0;
    repeat (4) step();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
